// File: rtl/tl_pkg.sv
// tl_pkg: TileLink opcodes, responder FSM states, field widths and beat math.
package tl_pkg;
  localparam logic [2:0] A_PUTFULL = 3'd0;
  localparam logic [2:0] A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] A_GET = 3'd4;
  localparam logic [2:0] D_ACCESSACK = 3'd0;
  localparam logic [2:0] D_ACCESSACKDATA = 3'd1;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SRC_W = 5;
  localparam int SIZE_W = 4;
  localparam int OP_W = 3;
  typedef enum logic [1:0] {IDLE, PUT_BURST, PUT_RESP, GET_DATA} state_t;
  // Oversized requests are clamped to 8 beats so a denied burst is still drained.
  function automatic logic [3:0] beats(input logic [SIZE_W-1:0] size);
    return size <= 4'd3 ? 4'd1 : size >= 4'd6 ? 4'd8 : 4'd1 << (size - 4'd3);
  endfunction
endpackage

// File: rtl/tl_ram_array.sv
// tl_ram_array: 64-bit byte-enabled SRAM with one write port and one registered read port.
module tl_ram_array #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wmask,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we)
      for (int i = 0; i < 8; i++)
        if (wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TileLink-UH manager backed by word-addressed SRAM.
// Optional TL_RAM_PERF_COUNTERS_EN adds saturating perf_gets/perf_puts/perf_denied outputs.
module tl_ram_responder
  import tl_pkg::*;
#(
  parameter logic [27:0] BASE_ADDR = 28'h000_0000,
  parameter int DEPTH_WORDS = 512,
  parameter int MAX_SIZE = 6
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [OP_W-1:0]   auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [SIZE_W-1:0] auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [OP_W-1:0]   auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_param,
  output logic [SIZE_W-1:0] auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic              auto_in_d_bits_sink,
  output logic              auto_in_d_bits_denied,
  output logic [DATA_W-1:0] auto_in_d_bits_data,
  output logic              auto_in_d_bits_corrupt
`ifdef TL_RAM_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_gets,
  output logic [31:0]       perf_puts,
  output logic [15:0]       perf_denied
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BASE32 = {4'b0, BASE_ADDR};
  localparam logic [31:0] LIMIT = BASE32 + 32'(DEPTH_WORDS * 8);
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);
  state_t state;
  logic [AW-1:0] widx, idx;
  logic [2:0] cnt, last;
  logic [31:0] addr32, span;
  logic [27:0] off;
  logic [63:0] rdata;
  logic legal, a_fire, d_fire, a_get, we, re, unused;
  assign addr32 = {4'b0, auto_in_a_bits_address};
  assign span = 32'd1 << auto_in_a_bits_size;
  assign legal = (auto_in_a_bits_opcode == A_PUTFULL || auto_in_a_bits_opcode == A_PUTPARTIAL ||
                  auto_in_a_bits_opcode == A_GET) && auto_in_a_bits_size <= MAX_SZ &&
                 (addr32 & (span - 32'd1)) == 32'd0 && addr32 >= BASE32 && addr32 + span <= LIMIT;
  assign off = auto_in_a_bits_address - BASE_ADDR;
  // Opcodes 4..7 carry no data beats, so they take the Get path when denied.
  assign a_get = auto_in_a_bits_opcode[2];
  assign auto_in_a_ready = state == IDLE || state == PUT_BURST;
  assign a_fire = auto_in_a_valid && auto_in_a_ready;
  assign d_fire = auto_in_d_valid && auto_in_d_ready;
  assign idx = state == IDLE ? off[AW+2:3] : widx + AW'(cnt);
  assign we = a_fire && !auto_in_a_bits_corrupt &&
              (state == IDLE ? legal && !a_get : !auto_in_d_bits_denied);
  assign re = (state == IDLE && a_fire && a_get) || (state == GET_DATA && !auto_in_d_valid);
  assign auto_in_d_bits_data = state == GET_DATA && !auto_in_d_bits_denied ? rdata : '0;
  assign auto_in_d_bits_param = 2'd0;
  assign auto_in_d_bits_sink = 1'b0;
  assign unused = ^{auto_in_a_bits_param, off};
  tl_ram_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clock(clock),
    .we(we),
    .waddr(idx),
    .wmask(auto_in_a_bits_mask),
    .wdata(auto_in_a_bits_data),
    .re(re),
    .raddr(idx),
    .rdata(rdata)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= '0;
      widx <= '0;
      auto_in_d_valid <= 1'b0;
      auto_in_d_bits_opcode <= '0;
      auto_in_d_bits_size <= '0;
      auto_in_d_bits_source <= '0;
      auto_in_d_bits_denied <= 1'b0;
      auto_in_d_bits_corrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_fire) begin
          widx <= off[AW+2:3];
          last <= 3'(beats(auto_in_a_bits_size) - 4'd1);
          auto_in_d_bits_size <= auto_in_a_bits_size;
          auto_in_d_bits_source <= auto_in_a_bits_source;
          auto_in_d_bits_denied <= !legal;
          auto_in_d_bits_opcode <= a_get ? D_ACCESSACKDATA : D_ACCESSACK;
          auto_in_d_bits_corrupt <= a_get && !legal;
          cnt <= a_get ? 3'd0 : 3'd1;
          if (a_get) begin
            state <= GET_DATA;
            auto_in_d_valid <= 1'b1;
          end else if (beats(auto_in_a_bits_size) > 4'd1) begin
            state <= PUT_BURST;
          end else begin
            state <= PUT_RESP;
            auto_in_d_valid <= 1'b1;
          end
        end
        PUT_BURST: if (a_fire) begin
          cnt <= cnt == last ? 3'd0 : cnt + 3'd1;
          if (cnt == last) begin
            state <= PUT_RESP;
            auto_in_d_valid <= 1'b1;
          end
        end
        PUT_RESP: if (d_fire) begin
          state <= IDLE;
          auto_in_d_valid <= 1'b0;
        end
        GET_DATA: if (d_fire) begin
          auto_in_d_valid <= 1'b0;
          cnt <= cnt == last ? 3'd0 : cnt + 3'd1;
          if (cnt == last) state <= IDLE;
        end else if (!auto_in_d_valid) begin
          auto_in_d_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TL_RAM_PERF_COUNTERS_EN
  logic first_fire;
  assign first_fire = state == IDLE && a_fire;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_gets <= '0;
      perf_puts <= '0;
      perf_denied <= '0;
    end else begin
      if (first_fire && auto_in_a_bits_opcode == A_GET && perf_gets != '1) perf_gets <= perf_gets + 32'd1;
      if (first_fire && (auto_in_a_bits_opcode == A_PUTFULL || auto_in_a_bits_opcode == A_PUTPARTIAL) &&
          perf_puts != '1) perf_puts <= perf_puts + 32'd1;
      if (first_fire && !legal && perf_denied != '1) perf_denied <= perf_denied + 16'd1;
    end
  end
`endif
endmodule
